// File: rtl/mc_pkg.sv
// mc_pkg: constants shared by the multicycle control FSM, its funct decoder and
// anything that talks to alu32 (datapath, alu32 benches).
//   - opcode / funct encodings of the supported MIPS subset
//   - alu_control encodings understood by alu32
//   - datapath mux select encodings
//   - FSM state encoding (state_t)
package mc_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // alu32 operation select
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encoding; codes 13..15 are unreachable and recover to FETCH.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REX    = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_BLTZ   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

endpackage

// File: rtl/mc_control_alu_dec.sv
// mc_control_alu_dec: combinational R-type funct decoder.
// Ports:
//   funct_i        in  6  instr[5:0]
//   alu_control_o  out 3  alu32 operation for this funct (ADD when unknown)
//   funct_ok_o     out 1  funct is one of the supported R-type operations
// The FSM decides when this result is actually presented to alu32.
module mc_control_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_ok_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    funct_ok_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_SLT:  alu_control_o = ALU_SLT;
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_MUL:  alu_control_o = ALU_MUL;
      FN_NOR:  alu_control_o = ALU_NOR;
      default: funct_ok_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset control FSM driving the alu32 datapath.
// Sequences FETCH / DECODE / execute / memory / writeback, drives the datapath
// muxes, write enables and alu_control, and resolves beq/bltz from alu32 flags.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   opcode, funct         fields of the instruction register
//   flagz, flagn          alu32 zero / negative flags of the current cycle
//   mem_ready             memory read data valid this cycle
//   pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, pc_src, alu_control
//                         datapath controls (see mc_pkg for encodings)
//   illegal_op            one-cycle pulse on unsupported opcode or funct
//   state_o               current FSM state, for debug/observation
// Memory handshake: a read in FETCH or MEMRD completes in the first cycle in
// which mem_ready is high; the FSM holds its state and all outputs until then.
// Writes (MEMWR) never wait. With USE_MEM_READY=0, mem_ready is taken as 1.
module mc_control
  import mc_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               flagz,
  input  logic               flagn,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_control,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t     state_q, state_d;
  logic       rdy;
  logic [2:0] dec_alu;
  logic       dec_ok;

  assign rdy     = USE_MEM_READY ? mem_ready : 1'b1;
  assign state_o = STATE_W'(state_q);

  mc_control_alu_dec u_alu_dec (
    .funct_i       (funct),
    .alu_control_o (dec_alu),
    .funct_ok_o    (dec_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PCSRC_ALU;
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // PC + 4 is computed every FETCH cycle but only committed with the IR.
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (rdy) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_REX;
          OP_BEQ:       state_d = ST_BEQ;
          OP_BLTZ:      state_d = ST_BLTZ;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (rdy) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_REX: begin
        alu_src_a = 1'b1;
        if (dec_ok) begin
          alu_control = dec_alu;
          state_d     = ST_RWB;
        end else begin
          illegal_op = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_RWB: begin
        // funct is still held in the IR, so the REX operation stays on the ALU.
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        alu_control = dec_alu;
        state_d     = ST_FETCH;
      end
      ST_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        pc_en       = flagz;
        state_d     = ST_FETCH;
      end
      ST_BLTZ: begin
        // rt is $0, so A - 0 leaves A's sign on flagn.
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        pc_en       = flagn;
        state_d     = ST_FETCH;
      end
      ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset overrides everything so an aborted instruction never strobes.
    if (reset) begin
      state_d     = ST_FETCH;
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      pc_src      = PCSRC_ALU;
      alu_control = ALU_ADD;
      illegal_op  = 1'b0;
    end
  end

endmodule
